mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, maximum BUSY cycles before abort (legal range 2..1024).
REQ-004 SHALL use one clock, CLK; reset RST is asynchronous and active-high.
REQ-005 Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- if_req  in  1  instruction-fetch read request, held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle completion pulse to fetch port.
- if_rdata  out  DATA_W  fetch read data, valid while if_done.
- dm_req  in  1  data-port request, held until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_done  out  1  one-cycle completion pulse to data port.
- dm_rdata  out  DATA_W  load data, valid while dm_done.
- err  out  1  timeout flag, valid with either done pulse.
- mem_addr  out  ADDR_W  address to memory subsystem.
- mem_load  out  1  load strobe, held through BUSY.
- mem_store  out  1  store strobe, held through BUSY.
- mem_wdata  out  DATA_W  store data to memory subsystem.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion, sampled only in BUSY.

Function
REQ-006 SHALL implement FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-007 IDLE: if any req high at the clock edge, SHALL select a winner, latch its addr/we/wdata and owner, and enter BUSY; otherwise stay IDLE.
REQ-008 BUSY: mem_load = ~we and mem_store = we (fetch is always a load); strobes, mem_addr and mem_wdata held constant for the whole of BUSY.
REQ-009 BUSY: on mem_ready = 1, SHALL capture mem_rdata, clear err, drop strobes, and enter RESP.
REQ-010 BUSY: a cycle counter SHALL count from 0; on reaching TIMEOUT_CYC-1 with mem_ready low, SHALL drop strobes, set err = 1, set captured rdata = 0, and enter RESP.
REQ-011 If mem_ready and the timeout occur in the same cycle, mem_ready SHALL win and err = 0.
REQ-012 RESP: SHALL pulse exactly one of if_done/dm_done (the owner's) for one cycle, with rdata and err valid; then enter IDLE.
REQ-013 Minimum latency: req high at the edge ending cycle 0 -> strobe in cycle 1 -> done in cycle 2 when mem_ready is high in cycle 1.
REQ-014 Requesters SHALL drop req in the cycle after done; a req still high in IDLE is a new request.
REQ-015 Requester inputs that change during BUSY/RESP SHALL be ignored; mem_ready outside BUSY SHALL be ignored.
REQ-016 Non-owner done SHALL stay 0; rdata outputs SHALL hold their last value when done is low.

Reset
REQ-017 RST SHALL immediately force IDLE, counter 0, all strobes/done/err 0, mem_addr/mem_wdata/rdata outputs 0, and last-owner = IF.
REQ-018 Reset mid-BUSY SHALL abort the transaction with no done pulse; strobes SHALL fall without waiting for a clock.

Configuration
REQ-019 With ARB_ROUND_ROBIN_EN defined, on simultaneous requests the port that did not own the previous grant SHALL win (first tie after reset goes to DM); a lone request SHALL always win.
REQ-020 Without ARB_ROUND_ROBIN_EN, DM SHALL always beat IF on simultaneous requests and no last-owner register SHALL exist.

Structure
REQ-021 Package mem_arb_pkg SHALL hold the state enum, the owner encoding (OWN_IF, OWN_DM), and the default TIMEOUT_CYC constant.
REQ-022 Winner selection SHALL live in the sub-module mem_arb_pick (inputs if_req, dm_req, last_owner; output winner); the FSM and datapath SHALL stay in mem_arbiter.

Verification
REQ-023 dm_req, dm_we = 0, dm_addr 0x04, mem_ready high on the 1st BUSY cycle with mem_rdata 0xDEADBEEF -> mem_load for 1 cycle, dm_done in cycle 2, dm_rdata 0xDEADBEEF, err 0.
REQ-024 if_req and dm_req both high, dm_we = 1 -> fixed mode: DM served first, then IF; RR mode: DM, IF, and on the next tie IF loses to DM only if IF won last.
REQ-025 Load to 0x19, mem_ready never asserted, TIMEOUT_CYC = 8 -> strobes high exactly 8 cycles, dm_done with err 1 and dm_rdata 0.
REQ-026 mem_ready asserted in the same cycle the counter hits TIMEOUT_CYC-1 -> done with err 0 and captured data.
REQ-027 RST pulsed in BUSY cycle 3 -> strobes low asynchronously, no done, next request served normally from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, owner encoding and timeout default for the memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;
    localparam int TIMEOUT_CYC_DEF = 64;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: chooses the winning port; on a tie the port that did not own the last grant wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
    input  owner_e last_owner,
    output owner_e winner
);
    always_comb winner = (if_req && dm_req) ? ((last_owner == OWN_IF) ? OWN_DM : OWN_IF)
                                            : (dm_req ? OWN_DM : OWN_IF);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto one memory port with timeout abort.
// ARB_ROUND_ROBIN_EN: alternate ties between ports; otherwise DM always wins ties.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic              mem_store,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d, winner, last_owner;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              load_q, load_d, store_q, store_d, err_q, err_d;
    logic              if_done_q, if_done_d, dm_done_q, dm_done_d;

    mem_arb_pick u_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .last_owner(last_owner),
        .winner    (winner)
    );

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;
    assign last_owner = last_q;
    always_comb last_d = (state_q == ST_IDLE && (if_req || dm_req)) ? winner : last_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) last_q <= OWN_IF;
        else     last_q <= last_d;
    end
`else
    // A constant IF history makes every tie resolve to DM.
    assign last_owner = OWN_IF;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        load_d     = load_q;
        store_d    = store_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (if_req || dm_req) begin
                state_d = ST_BUSY;
                owner_d = winner;
                cnt_d   = '0;
                addr_d  = (winner == OWN_DM) ? dm_addr : if_addr;
                wdata_d = (winner == OWN_DM) ? dm_wdata : '0;
                store_d = (winner == OWN_DM) && dm_we;
                load_d  = !((winner == OWN_DM) && dm_we);
            end
            // mem_ready wins over a coincident timeout.
            ST_BUSY: if (mem_ready || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d    = ST_RESP;
                load_d     = 1'b0;
                store_d    = 1'b0;
                err_d      = !mem_ready;
                if_done_d  = (owner_q == OWN_IF);
                dm_done_d  = (owner_q == OWN_DM);
                if_rdata_d = (owner_q == OWN_IF) ? (mem_ready ? mem_rdata : '0) : if_rdata_q;
                dm_rdata_d = (owner_q == OWN_DM) ? (mem_ready ? mem_rdata : '0) : dm_rdata_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            load_q     <= load_d;
            store_q    <= store_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
        end
    end

    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_load  = load_q;
    assign mem_store = store_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level checks of mem_arbiter against a simple arbitration/latency model.
module tb_mem_arbiter;
    localparam int T = 8;

    logic        CLK = 1'b0, RST = 1'b0;
    logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ready = 0;
    logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic        if_done, dm_done, err, mem_load, mem_store;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    int          checks = 0, errors = 0;
    logic        ref_last_dm = 0;
    logic [31:0] exp_if_rd = 0, exp_dm_rd = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T)) dut (
        .CLK(CLK), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .err(err),
        .mem_addr(mem_addr), .mem_load(mem_load), .mem_store(mem_store),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_dm(input logic ir, input logic dr);
`ifdef ARB_ROUND_ROBIN_EN
        return dr && (!ir || !ref_last_dm);
`else
        return dr;
`endif
    endfunction

    // Called at the falling edge of an IDLE cycle with requests already driven.
    // d = BUSY cycle index (0-based) in which mem_ready is raised.
    task automatic serve(input int d, input logic [31:0] rd, input string tag);
        logic        w_dm, est, exp_err, got_if, got_dm;
        logic [31:0] ea, ew, exp_rd;
        int          exp_len, strobes, done_at;
        w_dm    = pick_dm(if_req, dm_req);
        ea      = w_dm ? dm_addr : if_addr;
        ew      = dm_wdata;
        est     = w_dm && dm_we;
        exp_err = (d >= T);
        exp_len = exp_err ? T : d + 1;
        exp_rd  = exp_err ? 32'h0 : rd;
        strobes = 0;
        done_at = -1;
        got_if  = 0;
        got_dm  = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        for (int c = 1; c <= T + 3 && done_at < 0; c++) begin
            @(negedge CLK);
            if (mem_load || mem_store) begin
                strobes++;
                chk({tag, "_addr"}, mem_addr, ea);
                chk({tag, "_store"}, mem_store, est);
                chk({tag, "_load"}, mem_load, !est);
                if (est) chk({tag, "_wdata"}, mem_wdata, ew);
            end
            if (if_done || dm_done) begin
                done_at = c;
                got_if  = if_done;
                got_dm  = dm_done;
            end
            mem_ready = (c == d + 1) ? 1'b1 : (c > d + 1 ? 1'($urandom_range(0, 1)) : 1'b0);
            mem_rdata = (c == d + 1) ? rd : $urandom;
            if_addr   = $urandom;
            dm_addr   = $urandom;
            dm_wdata  = $urandom;
            dm_we     = 1'($urandom_range(0, 1));
        end
        if (w_dm) exp_dm_rd = exp_rd;
        else      exp_if_rd = exp_rd;
        chk({tag, "_strobe_len"}, strobes, exp_len);
        chk({tag, "_done_cycle"}, done_at, exp_len + 1);
        chk({tag, "_dm_done"}, got_dm, w_dm);
        chk({tag, "_if_done"}, got_if, !w_dm);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_if_rdata"}, if_rdata, exp_if_rd);
        chk({tag, "_dm_rdata"}, dm_rdata, exp_dm_rd);
        ref_last_dm = w_dm;
        @(negedge CLK);
        chk({tag, "_done_pulse"}, {if_done, dm_done}, 2'b00);
        chk({tag, "_idle_strobe"}, {mem_load, mem_store}, 2'b00);
        chk({tag, "_rdata_hold"}, {if_rdata, dm_rdata}, {exp_if_rd, exp_dm_rd});
        if (w_dm) dm_req = 0;
        else      if_req = 0;
    endtask

    initial begin
        logic [1:0] r;
        #1 RST = 1;
        #1;
        chk("rst_strobes", {mem_load, mem_store}, 2'b00);
        chk("rst_done", {if_done, dm_done, err}, 3'b000);
        chk("rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        @(negedge CLK);
        RST = 0;
        repeat (2) @(negedge CLK);
        chk("idle_no_req", {mem_load, mem_store, if_done, dm_done}, 4'b0000);

        dm_req = 1; dm_we = 0; dm_addr = 32'h04;
        serve(0, 32'hDEADBEEF, "dm_load");

        if_req = 1; dm_req = 1; dm_we = 1; if_addr = 32'h100; dm_addr = 32'h200; dm_wdata = 32'hA5A5_0001;
        serve(1, $urandom, "tie1_a");
        serve(0, $urandom, "tie1_b");
        if_req = 1; dm_req = 1; dm_we = 1;
        serve(2, $urandom, "tie2_a");
        dm_req = 1; if_req = 1;
        serve(0, $urandom, "tie2_b");
        serve(1, $urandom, "tie2_c");

        dm_req = 1; dm_we = 0; dm_addr = 32'h19;
        serve(1000, $urandom, "timeout");
        dm_req = 1; dm_we = 0;
        serve(T - 1, 32'h1234_5678, "ready_at_limit");
        if_req = 1; if_addr = 32'h40;
        serve(3, $urandom, "if_load");

        dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h5555_AAAA; mem_ready = 0;
        repeat (3) @(negedge CLK);
        chk("rst_mid_pre", mem_store, 1'b1);
        #1 RST = 1;
        #1;
        chk("rst_mid_strobes", {mem_load, mem_store}, 2'b00);
        chk("rst_mid_addr", mem_addr, 32'h0);
        @(negedge CLK);
        RST = 0; dm_req = 0; ref_last_dm = 0; exp_if_rd = 0; exp_dm_rd = 0;
        repeat (3) begin
            @(negedge CLK);
            chk("rst_mid_no_done", {if_done, dm_done, mem_load, mem_store}, 4'b0000);
        end
        if_req = 1; dm_req = 1; dm_we = 0;
        serve(0, $urandom, "post_rst_a");
        serve(2, $urandom, "post_rst_b");

        for (int i = 0; i < 25; i++) begin
            if (!if_req && !dm_req) begin
                r = 2'($urandom_range(1, 3));
                if_req = r[0];
                dm_req = r[1];
            end else if ($urandom_range(0, 1) == 1) begin
                if_req = 1;
                dm_req = 1;
            end
            if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
            dm_we = 1'($urandom_range(0, 1));
            serve(int'($urandom_range(0, T + 2)), $urandom, "rand");
        end
        for (int i = 0; i < 2; i++)
            if (if_req || dm_req) serve(0, $urandom, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
